spi_frame_loader: RTL and testbench

- Upstream feeder for the SRAM wrapper's SPI image-input port.
- Takes the raw byte stream from the SPI slave receiver and assembles each pair of bytes into an RGB565 pixel.
- Tags each pixel with raster coordinates and buffers it in a small pixel FIFO.
- Presents the FIFO head on the ready/read handshake that the SRAM wrapper consumes while freeze-framed.

---
 rtl/spi_frame_loader_if.sv | 26 ++
 rtl/spi_frame_loader.sv | 179 +++++++++++++++++
 tb/tb_spi_frame_loader.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_frame_loader_if.sv
// Pixel handshake between spi_frame_loader (master) and the SRAM wrapper's SPI image port (slave).
interface spi_frame_loader_if #(
    parameter int unsigned PRECISION = 11
);
    logic                        spi_pixel_ready;
    logic                        spi_pixel_read;
    logic [15:0]                 spi_pixel_in;
    logic signed [PRECISION:0]   spi_pixel_x;
    logic signed [PRECISION:0]   spi_pixel_y;

    modport master (
        output spi_pixel_ready,
        output spi_pixel_in,
        output spi_pixel_x,
        output spi_pixel_y,
        input  spi_pixel_read
    );

    modport slave (
        input  spi_pixel_ready,
        input  spi_pixel_in,
        input  spi_pixel_x,
        input  spi_pixel_y,
        output spi_pixel_read
    );
endinterface

// File: rtl/spi_frame_loader.sv
// Assembles SPI byte pairs into RGB565 pixels tagged with raster x/y and buffers them in a small FIFO.
// Optional build macro SPI_LOADER_LITTLE_ENDIAN_EN: first byte of each pair is the low byte.
module spi_frame_loader #(
    parameter int unsigned X_RES      = 800,
    parameter int unsigned Y_RES      = 600,
    parameter int unsigned PRECISION  = 11,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       frame_start,
    input  logic                       byte_valid,
    input  logic [7:0]                 byte_data,
    spi_frame_loader_if.master         pix,
    output logic                       frame_done,
    output logic                       overflow
);

    localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned PW = AW + 1;
    localparam int unsigned CW = PRECISION;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RECV,
        ST_DONE
    } state_t;

    state_t           r_state;
    logic             r_phase;
    logic [7:0]       r_first;
    logic [CW-1:0]    r_x;
    logic [CW-1:0]    r_y;
    logic             r_frame_done;
    logic             r_overflow;

    logic [PW-1:0]    r_wr;
    logic [PW-1:0]    r_rd;
    logic [15:0]      r_mem_pix [FIFO_DEPTH];
    logic [CW-1:0]    r_mem_x   [FIFO_DEPTH];
    logic [CW-1:0]    r_mem_y   [FIFO_DEPTH];
    logic             r_ready;
    logic [15:0]      r_head_pix;
    logic [CW-1:0]    r_head_x;
    logic [CW-1:0]    r_head_y;

    logic [15:0]      w_pixel;
    logic             w_complete;
    logic             w_empty;
    logic             w_full;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;
    logic             w_x_last;
    logic             w_y_last;
    logic             w_last;
    logic [PW-1:0]    w_wr_next;
    logic [PW-1:0]    w_rd_next;
    logic             w_head_from_push;

`ifdef SPI_LOADER_LITTLE_ENDIAN_EN
    assign w_pixel = {byte_data, r_first};
`else
    assign w_pixel = {r_first, byte_data};
`endif

    // A restart strobe pre-empts any pixel completion in the same cycle.
    assign w_complete = (r_state == ST_RECV) && !frame_start && byte_valid && r_phase;

    assign w_empty   = (r_wr == r_rd);
    assign w_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
    assign w_pop     = pix.spi_pixel_read && !w_empty;
    assign w_push    = w_complete && (!w_full || w_pop);
    assign w_drop    = w_complete && !w_push;

    assign w_x_last  = (r_x == CW'(X_RES - 1));
    assign w_y_last  = (r_y == CW'(Y_RES - 1));
    assign w_last    = w_complete && w_x_last && w_y_last;

    assign w_wr_next = r_wr + PW'(w_push);
    assign w_rd_next = r_rd + PW'(w_pop);

    // Next head slot equals the slot being written only when the FIFO drains to empty this cycle.
    assign w_head_from_push = w_push && (w_rd_next[AW-1:0] == r_wr[AW-1:0]);

    // Frame/byte sequencing, raster counters and status flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_phase      <= 1'b0;
            r_first      <= 8'd0;
            r_x          <= '0;
            r_y          <= '0;
            r_frame_done <= 1'b0;
            r_overflow   <= 1'b0;
        end else begin
            r_frame_done <= w_last;
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            if (frame_start) begin
                r_state    <= ST_RECV;
                r_x        <= '0;
                r_y        <= '0;
                r_overflow <= 1'b0;
                r_phase    <= byte_valid;
                if (byte_valid) begin
                    r_first <= byte_data;
                end
            end else begin
                case (r_state)
                    ST_RECV: begin
                        if (byte_valid) begin
                            if (!r_phase) begin
                                r_first <= byte_data;
                                r_phase <= 1'b1;
                            end else begin
                                r_phase <= 1'b0;
                                if (w_x_last) begin
                                    r_x <= '0;
                                    r_y <= w_y_last ? '0 : r_y + CW'(1);
                                end else begin
                                    r_x <= r_x + CW'(1);
                                end
                                if (w_x_last && w_y_last) begin
                                    r_state <= ST_DONE;
                                end
                            end
                        end
                    end
                    default: begin
                    end
                endcase
            end
        end
    end

    // FIFO storage; contents need no reset since pointers gate validity.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem_pix[r_wr[AW-1:0]] <= w_pixel;
            r_mem_x[r_wr[AW-1:0]]   <= r_x;
            r_mem_y[r_wr[AW-1:0]]   <= r_y;
        end
    end

    // Pointers and registered head presentation.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr       <= '0;
            r_rd       <= '0;
            r_ready    <= 1'b0;
            r_head_pix <= 16'd0;
            r_head_x   <= '0;
            r_head_y   <= '0;
        end else begin
            r_wr    <= w_wr_next;
            r_rd    <= w_rd_next;
            r_ready <= (w_wr_next != w_rd_next);
            if (w_head_from_push) begin
                r_head_pix <= w_pixel;
                r_head_x   <= r_x;
                r_head_y   <= r_y;
            end else begin
                r_head_pix <= r_mem_pix[w_rd_next[AW-1:0]];
                r_head_x   <= r_mem_x[w_rd_next[AW-1:0]];
                r_head_y   <= r_mem_y[w_rd_next[AW-1:0]];
            end
        end
    end

    assign pix.spi_pixel_ready = r_ready;
    assign pix.spi_pixel_in    = r_head_pix;
    assign pix.spi_pixel_x     = $signed({1'b0, r_head_x});
    assign pix.spi_pixel_y     = $signed({1'b0, r_head_y});
    assign frame_done          = r_frame_done;
    assign overflow            = r_overflow;

endmodule

// File: tb/tb_spi_frame_loader.sv
// Randomized plus directed bench for spi_frame_loader against a queue-based pixel model.
module tb_spi_frame_loader;

    localparam int unsigned XR    = 4;
    localparam int unsigned YR    = 3;
    localparam int unsigned PREC  = 11;
    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic       fs;
    logic       bv;
    logic [7:0] bd;
    logic       fd;
    logic       ovf;

    always #5 clk = ~clk;

    spi_frame_loader_if #(.PRECISION(PREC)) pif ();

    spi_frame_loader #(
        .X_RES(XR), .Y_RES(YR), .PRECISION(PREC), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk),
        .rst(rst),
        .frame_start(fs),
        .byte_valid(bv),
        .byte_data(bd),
        .pix(pif),
        .frame_done(fd),
        .overflow(ovf)
    );

    typedef struct {
        logic [15:0] pix;
        int          x;
        int          y;
    } ent_t;

    ent_t       m_q[$];
    bit         m_active;
    bit         m_pend;
    logic [7:0] m_first;
    int         m_x;
    int         m_y;
    bit         m_ovf;
    bit         m_done;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    logic [7:0] b_f800_0, b_f800_1;

    function automatic logic [15:0] mkpix(input logic [7:0] first, input logic [7:0] second);
`ifdef SPI_LOADER_LITTLE_ENDIAN_EN
        return {second, first};
`else
        return {first, second};
`endif
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_active = 1'b0;
        m_pend   = 1'b0;
        m_first  = 8'd0;
        m_x      = 0;
        m_y      = 0;
        m_ovf    = 1'b0;
        m_done   = 1'b0;
    endtask

    // One clock of the pixel stream: pop, then complete/push, then byte/frame bookkeeping.
    task automatic model_step(input bit f, input bit v, input logic [7:0] d, input bit r);
        bit   dopop;
        bit   cmpl;
        ent_t e;
        dopop  = r && (m_q.size() > 0);
        cmpl   = !f && m_active && v && m_pend;
        m_done = 1'b0;
        if (dopop) void'(m_q.pop_front());
        if (cmpl) begin
            e.pix = mkpix(m_first, d);
            e.x   = m_x;
            e.y   = m_y;
            if (m_q.size() < DEPTH) m_q.push_back(e);
            else m_ovf = 1'b1;
            m_done = (m_x == XR - 1) && (m_y == YR - 1);
            m_pend = 1'b0;
            m_x++;
            if (m_x == XR) begin
                m_x = 0;
                m_y++;
            end
            if (m_done) m_active = 1'b0;
        end else if (f) begin
            m_active = 1'b1;
            m_x      = 0;
            m_y      = 0;
            m_ovf    = 1'b0;
            m_pend   = v;
            m_first  = d;
        end else if (m_active && v && !m_pend) begin
            m_pend  = 1'b1;
            m_first = d;
        end
    endtask

    task automatic step(input bit f, input bit v, input logic [7:0] d, input bit r);
        fs = f; bv = v; bd = d; pif.spi_pixel_read = r;
        @(posedge clk);
        model_step(f, v, d, r);
        @(negedge clk);
        fs = 1'b0; bv = 1'b0; pif.spi_pixel_read = 1'b0;
    endtask

    task automatic send_pix(input logic [7:0] a, input logic [7:0] b, input bit r);
        step(1'b0, 1'b1, a, r);
        step(1'b0, 1'b1, b, r);
    endtask

    // Per-cycle comparison of DUT outputs against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ready", 32'(pif.spi_pixel_ready), 32'(m_q.size() != 0));
            if (m_q.size() != 0) begin
                chk("pixel", 32'(pif.spi_pixel_in), 32'(m_q[0].pix));
                chk("x", 32'(pif.spi_pixel_x), 32'(m_q[0].x));
                chk("y", 32'(pif.spi_pixel_y), 32'(m_q[0].y));
            end
            chk("overflow", 32'(ovf), 32'(m_ovf));
            chk("frame_done", 32'(fd), 32'(m_done));
        end
    end

    initial begin
        int cap_x[$];
        int cap_y[$];
        int fd_cnt;
        bit f, v, r;
        int rd_pct;

`ifdef SPI_LOADER_LITTLE_ENDIAN_EN
        b_f800_0 = 8'h00; b_f800_1 = 8'hF8;
`else
        b_f800_0 = 8'hF8; b_f800_1 = 8'h00;
`endif
        rst = 1'b1; fs = 1'b0; bv = 1'b0; bd = 8'd0; pif.spi_pixel_read = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(pif.spi_pixel_ready), 32'd0);
        chk("rst_pixel", 32'(pif.spi_pixel_in), 32'd0);
        chk("rst_x", 32'(pif.spi_pixel_x), 32'd0);
        chk("rst_y", 32'(pif.spi_pixel_y), 32'd0);
        chk("rst_done", 32'(fd), 32'd0);
        chk("rst_ovf", 32'(ovf), 32'd0);
        rst = 1'b0;
        chk_en = 1'b1;

        // First pixel then a single ack.
        step(1'b1, 1'b0, 8'd0, 1'b0);
        send_pix(b_f800_0, b_f800_1, 1'b0);
        chk("t1_ready", 32'(pif.spi_pixel_ready), 32'd1);
        chk("t1_pixel", 32'(pif.spi_pixel_in), 32'hF800);
        chk("t1_x", 32'(pif.spi_pixel_x), 32'd0);
        chk("t1_y", 32'(pif.spi_pixel_y), 32'd0);
        step(1'b0, 1'b0, 8'd0, 1'b1);
        chk("t1_ready_after_read", 32'(pif.spi_pixel_ready), 32'd0);

        // Full frame with immediate acks, then a 13th pixel that must be ignored.
        fd_cnt = 0;
        step(1'b1, 1'b0, 8'd0, 1'b1);
        for (int p = 0; p < 13; p++) begin
            for (int k = 0; k < 2; k++) begin
                step(1'b0, 1'b1, 8'(p * 2 + k), 1'b1);
                if (pif.spi_pixel_ready) begin
                    cap_x.push_back(int'(pif.spi_pixel_x));
                    cap_y.push_back(int'(pif.spi_pixel_y));
                end
                if (fd) fd_cnt++;
            end
        end
        repeat (2) step(1'b0, 1'b0, 8'd0, 1'b1);
        chk("t2_count", 32'(cap_x.size()), 32'd12);
        chk("t2_done_pulses", 32'(fd_cnt), 32'd1);
        for (int i = 0; i < 12 && i < cap_x.size(); i++) begin
            chk("t2_x", 32'(cap_x[i]), 32'(i % 4));
            chk("t2_y", 32'(cap_y[i]), 32'(i / 4));
        end

        // Overflow: five pixels with no reads.
        step(1'b1, 1'b0, 8'd0, 1'b0);
        for (int p = 0; p < 5; p++) send_pix(8'(p), 8'(p + 16), 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b0);
        chk("t3_ovf", 32'(ovf), 32'd1);
        for (int k = 0; k < 4; k++) begin
            chk("t3_drain_x", 32'(pif.spi_pixel_x), 32'(k));
            step(1'b0, 1'b0, 8'd0, 1'b1);
        end
        chk("t3_empty", 32'(pif.spi_pixel_ready), 32'd0);
        send_pix(8'hA5, 8'h5A, 1'b0);
        chk("t3_next_x", 32'(pif.spi_pixel_x), 32'd1);
        chk("t3_next_y", 32'(pif.spi_pixel_y), 32'd1);
        step(1'b0, 1'b0, 8'd0, 1'b1);

        // Restart discards a latched first byte.
        step(1'b1, 1'b0, 8'd0, 1'b0);
        step(1'b0, 1'b1, 8'h12, 1'b0);
        step(1'b1, 1'b0, 8'd0, 1'b0);
        send_pix(8'h34, 8'h56, 1'b0);
`ifdef SPI_LOADER_LITTLE_ENDIAN_EN
        chk("t4_pixel", 32'(pif.spi_pixel_in), 32'h5634);
`else
        chk("t4_pixel", 32'(pif.spi_pixel_in), 32'h3456);
`endif
        chk("t4_x", 32'(pif.spi_pixel_x), 32'd0);
        step(1'b0, 1'b0, 8'd0, 1'b1);
        chk("t4_empty", 32'(pif.spi_pixel_ready), 32'd0);

        // Full FIFO with push and pop in the same cycle.
        step(1'b1, 1'b0, 8'd0, 1'b0);
        for (int p = 0; p < 4; p++) send_pix(8'(p), 8'(p), 1'b0);
        step(1'b0, 1'b1, 8'h77, 1'b0);
        step(1'b0, 1'b1, 8'h88, 1'b1);
        chk("t5_ovf", 32'(ovf), 32'd0);
        chk("t5_head_x", 32'(pif.spi_pixel_x), 32'd1);
        for (int k = 1; k < 5; k++) begin
            chk("t5_drain_x", 32'(pif.spi_pixel_x), 32'(k % 4));
            step(1'b0, 1'b0, 8'd0, 1'b1);
        end
        chk("t5_empty", 32'(pif.spi_pixel_ready), 32'd0);

        // Asynchronous reset mid-frame with two entries buffered.
        step(1'b1, 1'b0, 8'd0, 1'b0);
        send_pix(8'h11, 8'h22, 1'b0);
        send_pix(8'h33, 8'h44, 1'b0);
        step(1'b0, 1'b1, 8'h55, 1'b0);
        #2 rst = 1'b1;
        model_reset();
        #1;
        chk("t6_ready", 32'(pif.spi_pixel_ready), 32'd0);
        chk("t6_pixel", 32'(pif.spi_pixel_in), 32'd0);
        chk("t6_x", 32'(pif.spi_pixel_x), 32'd0);
        chk("t6_y", 32'(pif.spi_pixel_y), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        send_pix(8'hAA, 8'hBB, 1'b0);
        step(1'b0, 1'b0, 8'd0, 1'b0);
        chk("t6_ignored", 32'(pif.spi_pixel_ready), 32'd0);
        step(1'b1, 1'b0, 8'd0, 1'b0);
        send_pix(b_f800_0, b_f800_1, 1'b0);
        chk("t6_pixel_after", 32'(pif.spi_pixel_in), 32'hF800);
        step(1'b0, 1'b0, 8'd0, 1'b1);

        // Randomized traffic with varying consumer speed.
        for (int i = 0; i < 4000; i++) begin
            case ((i / 500) % 3)
                0:       rd_pct = 90;
                1:       rd_pct = 50;
                default: rd_pct = 10;
            endcase
            f = ($urandom_range(0, 99) == 0);
            v = ($urandom_range(0, 1) == 1);
            r = ($urandom_range(0, 99) < rd_pct);
            step(f, v, 8'($urandom), r);
        end

        chk_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
